i2s_slot_sequencer: RTL and testbench
=====================================

Name: i2s_slot_sequencer

Overview:
Next-generation I2S front end for the tuner audio path. It oversamples the external SCK/WS/SD lines in the system clock domain and tracks the bit position inside each WS half-frame with a parametrised counter. It exposes that position as a registered one-hot slot vector, deserialises the MSB-first sample word per channel, and flags framing errors, with automatic re-alignment after each error.

Parameters:
SLOT_WIDTH, 32, SCK periods per WS half-frame (per channel).
DATA_WIDTH, 24, sample bits captured per channel, MSB first. Legal range is 1 to SLOT_WIDTH-1.
CNT_WIDTH, $clog2(SLOT_WIDTH), bit-counter width (derived; do not override).

Ports:
clk_i  input  1  system clock. Must be at least 4x SCK; SCK high and low phases each at least 2 clk periods.
rst_i  input  1  asynchronous, active-high reset.
en_i  input  1  block enable, synchronous to clk_i.
sck_i  input  1  I2S bit clock, asynchronous.
ws_i  input  1  I2S word select, asynchronous. 0 = left, 1 = right.
sd_i  input  1  I2S serial data, asynchronous.
slot_o  output  SLOT_WIDTH  one-hot index of the next expected data bit. All zeros unless locked.
chan_o  output  1  channel of the half-frame in progress.
lock_o  output  1  high while in RUN.
sample_o  output  DATA_WIDTH  last completed sample word.
sample_chan_o  output  1  channel of sample_o.
sample_valid_o  output  1  one-clk strobe when sample_o is updated.
frame_err_o  output  1  one-clk strobe on a framing error.

Behaviour:
- Synchronisers: sck_i, ws_i and sd_i each pass through a 2-FF synchroniser (s1, s2). A third sck register (s3) drives edge detection: rise = s2 & ~s3.
- All state updates below happen only on clocks where rise = 1, using the synchronised ws and sd. ws_prev holds ws as it was at the previous rise.
- Edge rise: a rise where ws != ws_prev. Its sd is ignored, because it carries the previous word's last slot bit. Any other rise is a data rise.
- States: IDLE, ALIGN, RUN. Reset value is IDLE.
  - IDLE: en_i = 1 moves to ALIGN on the next clk.
  - ALIGN to RUN on an edge rise.
  - RUN to ALIGN on a framing error.
  - Any state to IDLE on the clk after en_i = 0. The partial word is discarded.
- On entering RUN, or on a legal edge rise in RUN:
  - bit_cnt <= 0.
  - chan_o <= ws.
  - Shift register cleared.
- Data rise in RUN:
  - If bit_cnt < DATA_WIDTH, shift sd into the LSB.
  - If bit_cnt == DATA_WIDTH-1:
    - sample_o <= completed word;
    - sample_chan_o <= chan_o;
    - sample_valid_o = 1 for exactly 1 clk.
  - Then bit_cnt increments.
- Framing errors, both checked in RUN only:
  - An edge rise with bit_cnt != SLOT_WIDTH-1 (short half-frame).
  - A data rise with bit_cnt == SLOT_WIDTH-1 (long half-frame).
  - Response: frame_err_o pulses for 1 clk, state goes to ALIGN, lock_o drops, no valid for the current word. A word already delivered stays delivered.
- Edge rises in ALIGN never raise an error. The partial word seen before the first lock is never reported.
- slot_o = 1 << bit_cnt, registered together with bit_cnt while in RUN. It is all zeros in IDLE and ALIGN.
- Latency: let n be the first clk edge that samples sck_i high. The rise is processed and outputs update at edge n+2.
- Reset (asynchronous, at any time): all outputs 0, bit_cnt 0, ws_prev 0, synchronisers 0, state IDLE. Reset mid-word loses the word with no strobe.
- No simultaneous-event conflicts exist: at most one rise is processed per clk, and error takes priority over capture.

Test Plan:
1. Default params, clk = 8x SCK, en_i = 1, stereo frames L = 0xA5A5A5, R = 0x5A5A5A. Required:
   - lock_o rises after the first WS edge;
   - the first partial word is not reported;
   - then sample_valid_o pulses alternately with sample_o/sample_chan_o = 0xA5A5A5/0 and 0x5A5A5A/1;
   - frame_err_o never asserts.
2. After lock, check slot_o: 32'h0000_0001 right after an edge rise, 32'h0000_0020 after 5 data rises, 32'h8000_0000 after 31 data rises.
3. Toggle WS after only 20 data rises. Required:
   - one frame_err_o pulse; lock_o = 0; slot_o = 0; no valid for that word;
   - lock regained at the next WS edge, and the following full word 0x123456 is delivered.
4. Hold WS for 40 rises. Required:
   - valid pulse at data rise 24;
   - frame_err_o on the 32nd data rise, then ALIGN.
5. Drop en_i mid-word at bit 10 → next clk lock_o = 0, slot_o = 0, no valid pulse. Assert rst_i mid-word → all outputs 0 immediately, without waiting for a clk edge.
6. SLOT_WIDTH = 16, DATA_WIDTH = 15, word 0x4001 → sample_o = 15'h4001, slot_o width 16, no errors across 4 frames.

Source files
------------

// File: rtl/i2s_slot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_slot_sequencer_if
// Brief    : Bundle of I2S line inputs, enable and slot/sample outputs for
//            the I2S slot sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_slot_sequencer_if #(
    parameter int SLOT_WIDTH = 32,
    parameter int DATA_WIDTH = 24
) ();
    logic                  en_i;
    logic                  sck_i;
    logic                  ws_i;
    logic                  sd_i;
    logic [SLOT_WIDTH-1:0] slot_o;
    logic                  chan_o;
    logic                  lock_o;
    logic [DATA_WIDTH-1:0] sample_o;
    logic                  sample_chan_o;
    logic                  sample_valid_o;
    logic                  frame_err_o;

    // Source side: drives the I2S lines and enable, observes results
    modport master (
        output en_i, sck_i, ws_i, sd_i,
        input  slot_o, chan_o, lock_o, sample_o, sample_chan_o,
               sample_valid_o, frame_err_o
    );

    // Sequencer side
    modport slave (
        input  en_i, sck_i, ws_i, sd_i,
        output slot_o, chan_o, lock_o, sample_o, sample_chan_o,
               sample_valid_o, frame_err_o
    );
endinterface
`default_nettype wire

// File: rtl/i2s_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_slot_sequencer
// Brief    : Oversampled I2S receiver front end. Tracks the bit slot inside
//            each WS half-frame, deserialises MSB-first samples per channel
//            and flags short/long half-frames with automatic re-alignment.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_slot_sequencer #(
    parameter int SLOT_WIDTH = 32,
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = $clog2(SLOT_WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    i2s_slot_sequencer_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0]  c_last_slot  = CNT_WIDTH'(SLOT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  c_last_data  = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  c_data_width = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [SLOT_WIDTH-1:0] c_slot_first = SLOT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Synchroniser stages
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_ws_s1,  r_ws_s2;
    logic r_sd_s1,  r_sd_s2;

    // Sequencer state
    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_bit_cnt;
    logic                  r_ws_prev;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [SLOT_WIDTH-1:0] r_slot;
    logic                  r_chan;
    logic                  r_lock;
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_sample_chan;
    logic                  r_sample_valid;
    logic                  r_frame_err;

    logic                  w_rise;
    logic                  w_ws_edge;
    logic [DATA_WIDTH-1:0] w_word;

    // Rising SCK seen in the clk domain; an edge rise is one where WS changed
    assign w_rise    = r_sck_s2 & ~r_sck_s3;
    assign w_ws_edge = r_ws_s2 ^ r_ws_prev;
    // Shift register with the current SD bit appended at the LSB
    assign w_word    = DATA_WIDTH'({r_shift, r_sd_s2});

    // Two-stage synchronisers; SCK gets a third stage for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_s3 <= 1'b0;
            r_ws_s1  <= 1'b0;
            r_ws_s2  <= 1'b0;
            r_sd_s1  <= 1'b0;
            r_sd_s2  <= 1'b0;
        end else begin
            r_sck_s1 <= bus.sck_i;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
            r_ws_s1  <= bus.ws_i;
            r_ws_s2  <= r_ws_s1;
            r_sd_s1  <= bus.sd_i;
            r_sd_s2  <= r_sd_s1;
        end
    end

    // Alignment FSM, slot counter, deserialiser and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_ws_prev      <= 1'b0;
            r_shift        <= '0;
            r_slot         <= '0;
            r_chan         <= 1'b0;
            r_lock         <= 1'b0;
            r_sample       <= '0;
            r_sample_chan  <= 1'b0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;

            // WS history is tracked on every rise so the first edge after
            // enabling is recognised without an extra half-frame
            if (w_rise) begin
                r_ws_prev <= r_ws_s2;
            end

            if (!bus.en_i) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_slot    <= '0;
                r_lock    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ALIGN;
                    end

                    ST_ALIGN: begin
                        // Lock on the first WS edge; earlier data is a partial word
                        if (w_rise && w_ws_edge) begin
                            r_state   <= ST_RUN;
                            r_lock    <= 1'b1;
                            r_bit_cnt <= '0;
                            r_slot    <= c_slot_first;
                            r_chan    <= r_ws_s2;
                            r_shift   <= '0;
                        end
                    end

                    ST_RUN: begin
                        if (w_rise && w_ws_edge) begin
                            if (r_bit_cnt == c_last_slot) begin
                                // Legal half-frame boundary: restart slot count
                                r_bit_cnt <= '0;
                                r_slot    <= c_slot_first;
                                r_chan    <= r_ws_s2;
                                r_shift   <= '0;
                            end else begin
                                // Short half-frame
                                r_frame_err <= 1'b1;
                                r_state     <= ST_ALIGN;
                                r_lock      <= 1'b0;
                                r_slot      <= '0;
                            end
                        end else if (w_rise) begin
                            if (r_bit_cnt == c_last_slot) begin
                                // Long half-frame: more data bits than slots
                                r_frame_err <= 1'b1;
                                r_state     <= ST_ALIGN;
                                r_lock      <= 1'b0;
                                r_slot      <= '0;
                            end else begin
                                if (r_bit_cnt < c_data_width) begin
                                    r_shift <= w_word;
                                end
                                if (r_bit_cnt == c_last_data) begin
                                    r_sample       <= w_word;
                                    r_sample_chan  <= r_chan;
                                    r_sample_valid <= 1'b1;
                                end
                                r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
                                r_slot    <= {r_slot[SLOT_WIDTH-2:0], 1'b0};
                            end
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.slot_o         = r_slot;
    assign bus.chan_o         = r_chan;
    assign bus.lock_o         = r_lock;
    assign bus.sample_o       = r_sample;
    assign bus.sample_chan_o  = r_sample_chan;
    assign bus.sample_valid_o = r_sample_valid;
    assign bus.frame_err_o    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_slot_sequencer
// Brief    : Scoreboard bench for i2s_slot_sequencer: a 32/24 instance and a
//            16/15 instance share the I2S lines, each with its own enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_slot_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic ws  = 1'b0;
    logic sd  = 1'b0;
    logic en1 = 1'b0;
    logic en2 = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int vcnt1  = 0;
    int ecnt1  = 0;
    int vcnt2  = 0;
    int ecnt2  = 0;

    logic [24:0] q1[$];
    logic [15:0] q2[$];

    always #5 clk = ~clk;

    i2s_slot_sequencer_if #(.SLOT_WIDTH(32), .DATA_WIDTH(24)) bus1 ();
    i2s_slot_sequencer_if #(.SLOT_WIDTH(16), .DATA_WIDTH(15)) bus2 ();

    assign bus1.en_i  = en1;
    assign bus1.sck_i = sck;
    assign bus1.ws_i  = ws;
    assign bus1.sd_i  = sd;
    assign bus2.en_i  = en2;
    assign bus2.sck_i = sck;
    assign bus2.ws_i  = ws;
    assign bus2.sd_i  = sd;

    i2s_slot_sequencer #(.SLOT_WIDTH(32), .DATA_WIDTH(24)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    i2s_slot_sequencer #(.SLOT_WIDTH(16), .DATA_WIDTH(15)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor for the 32/24 instance: pops expected samples on each strobe
    always @(negedge clk) begin
        if (!rst && bus1.sample_valid_o) begin
            vcnt1++;
            if (q1.size() == 0) begin
                chk("sb1_unexpected_valid", 64'(1), 64'(0));
            end else begin
                logic [24:0] e;
                e = q1.pop_front();
                chk("sb1_sample", 64'(bus1.sample_o), 64'(e[23:0]));
                chk("sb1_chan", 64'(bus1.sample_chan_o), 64'(e[24]));
            end
        end
        if (!rst && bus1.frame_err_o) ecnt1++;
    end

    // Monitor for the 16/15 instance
    always @(negedge clk) begin
        if (!rst && bus2.sample_valid_o) begin
            vcnt2++;
            if (q2.size() == 0) begin
                chk("sb2_unexpected_valid", 64'(1), 64'(0));
            end else begin
                logic [15:0] e;
                e = q2.pop_front();
                chk("sb2_sample", 64'(bus2.sample_o), 64'(e[14:0]));
                chk("sb2_chan", 64'(bus2.sample_chan_o), 64'(e[15]));
            end
        end
        if (!rst && bus2.frame_err_o) ecnt2++;
    end

    // One SCK period (8 clk): lines change while SCK is low, then SCK rises.
    // On return the rise has been processed by the DUT.
    task automatic sck_bit(input logic w, input logic d);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Data rises first..last (1-based) of a word, MSB first, padding with 1s
    task automatic data_rises(input logic w, input logic [31:0] word, input int dw,
                              input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sck_bit(w, (i <= dw) ? word[dw - i] : 1'b1);
        end
    endtask

    // Edge rise (its SD is junk 1) followed by nd data rises
    task automatic send_half(input int dut, input logic w, input logic [31:0] word,
                             input int dw, input int nd, input bit push);
        if (push) begin
            if (dut == 1) q1.push_back({w, word[23:0]});
            else          q2.push_back({w, word[14:0]});
        end
        sck_bit(w, 1'b1);
        data_rises(w, word, dw, 1, nd);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_lock", 64'(bus1.lock_o), 64'(0));
        chk("rst_slot", 64'(bus1.slot_o), 64'(0));
        chk("rst_sample", 64'(bus1.sample_o), 64'(0));
        chk("rst_valid", 64'(bus1.sample_valid_o), 64'(0));
        chk("rst_err", 64'(bus1.frame_err_o), 64'(0));
        rst = 1'b0;
        en1 = 1'b1;
        repeat (2) @(negedge clk);

        // Partial word before the first WS edge must not lock or report
        data_rises(1'b0, 32'h00C3_3C5A, 24, 1, 12);
        chk("pre_lock", 64'(bus1.lock_o), 64'(0));

        // First right half-frame with slot checks after every rise
        send_half(1, 1'b1, 32'h5A5A5A, 24, 0, 1);
        chk("lock_after_edge", 64'(bus1.lock_o), 64'(1));
        chk("slot_after_edge", 64'(bus1.slot_o), 64'h0000_0001);
        chk("chan_after_edge", 64'(bus1.chan_o), 64'(1));
        for (int k = 1; k <= 31; k++) begin
            data_rises(1'b1, 32'h5A5A5A, 24, k, k);
            if (k == 5 || k == 31) chk("slot_k", 64'(bus1.slot_o), 64'(32'h1 << k));
        end
        chk("slot_after_31", 64'(bus1.slot_o), 64'h8000_0000);
        send_half(1, 1'b0, 32'hA5A5A5, 24, 31, 1);
        send_half(1, 1'b1, 32'h5A5A5A, 24, 31, 1);
        send_half(1, 1'b0, 32'hA5A5A5, 24, 31, 1);
        chk("stereo_valid_cnt", 64'(vcnt1), 64'(4));
        chk("stereo_no_err", 64'(ecnt1), 64'(0));

        // Short half-frame: WS toggles after 20 data rises
        send_half(1, 1'b1, 32'h5A5A5A, 24, 20, 0);
        sck_bit(1'b0, 1'b1);
        chk("short_err", 64'(ecnt1), 64'(1));
        chk("short_lock", 64'(bus1.lock_o), 64'(0));
        chk("short_slot", 64'(bus1.slot_o), 64'(0));
        chk("short_no_valid", 64'(vcnt1), 64'(4));
        data_rises(1'b0, 32'h0, 24, 1, 31);
        send_half(1, 1'b1, 32'h123456, 24, 0, 1);
        chk("relock", 64'(bus1.lock_o), 64'(1));
        data_rises(1'b1, 32'h123456, 24, 1, 31);
        chk("relock_valid_cnt", 64'(vcnt1), 64'(5));

        // Long half-frame: WS held for 40 data rises
        send_half(1, 1'b0, 32'h0F1E2D, 24, 23, 1);
        chk("long_pre24", 64'(vcnt1), 64'(5));
        data_rises(1'b0, 32'h0F1E2D, 24, 24, 24);
        chk("long_at24", 64'(vcnt1), 64'(6));
        data_rises(1'b0, 32'h0F1E2D, 24, 25, 31);
        chk("long_pre32_err", 64'(ecnt1), 64'(1));
        chk("long_pre32_lock", 64'(bus1.lock_o), 64'(1));
        data_rises(1'b0, 32'h0F1E2D, 24, 32, 32);
        chk("long_err", 64'(ecnt1), 64'(2));
        chk("long_lock", 64'(bus1.lock_o), 64'(0));
        chk("long_slot", 64'(bus1.slot_o), 64'(0));
        data_rises(1'b0, 32'h0F1E2D, 24, 33, 40);
        chk("long_tail_err", 64'(ecnt1), 64'(2));

        // Enable dropped mid-word
        send_half(1, 1'b1, 32'h5A5A5A, 24, 31, 1);
        chk("pre_en_valid_cnt", 64'(vcnt1), 64'(7));
        send_half(1, 1'b0, 32'hA5A5A5, 24, 10, 0);
        en1 = 1'b0;
        @(negedge clk);
        chk("en_lock", 64'(bus1.lock_o), 64'(0));
        chk("en_slot", 64'(bus1.slot_o), 64'(0));
        data_rises(1'b0, 32'hA5A5A5, 24, 11, 31);
        chk("en_no_valid", 64'(vcnt1), 64'(7));
        en1 = 1'b1;
        @(negedge clk);
        send_half(1, 1'b1, 32'h5A5A5A, 24, 31, 1);
        chk("reen_valid_cnt", 64'(vcnt1), 64'(8));
        send_half(1, 1'b0, 32'hA5A5A5, 24, 10, 0);
        chk("pre_rst_lock", 64'(bus1.lock_o), 64'(1));

        // Asynchronous reset mid-word, checked before the next clk edge
        sck = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_lock", 64'(bus1.lock_o), 64'(0));
        chk("arst_slot", 64'(bus1.slot_o), 64'(0));
        chk("arst_sample", 64'(bus1.sample_o), 64'(0));
        chk("arst_sample_chan", 64'(bus1.sample_chan_o), 64'(0));
        chk("arst_chan", 64'(bus1.chan_o), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_valid", 64'(vcnt1), 64'(8));
        chk("sb1_drained", 64'(q1.size()), 64'(0));

        // 16-slot / 15-bit instance over four frames
        en2 = 1'b1;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            send_half(2, 1'b1, 32'h3FFE, 15, 15, 1);
            send_half(2, 1'b0, 32'h4001, 15, 15, 1);
        end
        sck_bit(1'b1, 1'b1);
        chk("w16_lock", 64'(bus2.lock_o), 64'(1));
        chk("w16_slot", 64'(bus2.slot_o), 64'h0001);
        chk("w16_no_err", 64'(ecnt2), 64'(0));
        chk("w16_valid_cnt", 64'(vcnt2), 64'(8));
        chk("sb2_drained", 64'(q2.size()), 64'(0));
        chk("dut1_idle_no_valid", 64'(vcnt1), 64'(8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
